// File: rtl/rv64g_reg_lock_tracker.sv
// Register scoreboard between launcher and execution units: per-register outstanding-write
// counters, jump interlock, and the lock vector fed back to the launcher.
package rv64g_pkg;
   localparam int NUM_REGS = 64;
endpackage

module rv64g_reg_lock_tracker #(
   parameter int NR  = rv64g_pkg::NUM_REGS,
   parameter int NWB = 2,
   parameter int CW  = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic                          launch_valid_i,
   output logic                          launch_ready_o,
   input  logic [$clog2(NR)-1:0]         launch_rd_i,
   input  logic                          launch_rd_we_i,
   input  logic                          launch_jump_i,
   output logic                          exec_valid_o,
   input  logic                          exec_ready_i,
   input  logic                          jump_resolve_i,
   input  logic [NWB-1:0]                wb_valid_i,
   input  logic [NWB-1:0][$clog2(NR)-1:0] wb_rd_i,
   output logic [NR-1:0]                 locks_o,
   output logic                          busy_o,
   output logic                          wb_err_o
);
   localparam int RW = $clog2(NR);
   // Wide enough for count+1 and down to -NWB without wrapping.
   localparam int SW = CW + $clog2(NWB + 1) + 1;

   logic [CW-1:0] r_cnt [NR];
   logic          r_jump_pending;
   logic          r_wb_err;

   logic [CW-1:0] w_cnt_next [NR];
   logic [NR-1:0] w_uflow;
   logic          w_sat;
   logic          w_block;
   logic          w_fire;

   function automatic logic [SW-1:0] wb_hits(input logic [NWB-1:0] v,
                                             input logic [NWB-1:0][RW-1:0] rd,
                                             input logic [RW-1:0] idx);
      logic [SW-1:0] n;
      n = '0;
      for (int p = 0; p < NWB; p++) begin
         if (v[p] && (rd[p] == idx)) n = n + SW'(1);
      end
      return n;
   endfunction

   assign w_sat   = launch_rd_we_i && (launch_rd_i != '0) && (r_cnt[launch_rd_i] == {CW{1'b1}});
   assign w_block = w_sat | r_jump_pending;

   assign exec_valid_o   = launch_valid_i & ~w_block;
   assign launch_ready_o = exec_ready_i & ~w_block;
   assign w_fire         = launch_valid_i & launch_ready_o;

   genvar gi;
   generate
      for (gi = 0; gi < NR; gi++) begin : g_reg
         if (gi == 0) begin : g_x0
            assign w_cnt_next[gi] = '0;
            assign w_uflow[gi]    = 1'b0;
            assign locks_o[gi]    = r_jump_pending;
         end else begin : g_track
            logic          w_inc;
            logic [SW-1:0] w_dec;
            logic [SW-1:0] w_up;
            assign w_inc = w_fire && launch_rd_we_i && (launch_rd_i == RW'(gi));
            assign w_dec = wb_hits(wb_valid_i, wb_rd_i, RW'(gi));
            assign w_up  = SW'(r_cnt[gi]) + SW'(w_inc);
            // Net delta of launch and writebacks; going negative clamps and flags an error.
            assign w_uflow[gi]    = (w_up < w_dec);
            assign w_cnt_next[gi] = w_uflow[gi] ? '0 : CW'(w_up - w_dec);
            assign locks_o[gi]    = (r_cnt[gi] != '0) | r_jump_pending;
         end
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NR; i++) r_cnt[i] <= '0;
         r_jump_pending <= 1'b0;
         r_wb_err       <= 1'b0;
      end else if (flush_i) begin
         for (int i = 0; i < NR; i++) r_cnt[i] <= '0;
         r_jump_pending <= 1'b0;
      end else begin
         for (int i = 0; i < NR; i++) r_cnt[i] <= w_cnt_next[i];
         // A resolve only clears an already-pending jump; a newly fired jump stays pending.
         r_jump_pending <= (r_jump_pending & ~jump_resolve_i) | (w_fire & launch_jump_i);
         r_wb_err       <= r_wb_err | (|w_uflow);
      end
   end

   assign busy_o   = |locks_o;
   assign wb_err_o = r_wb_err;

endmodule

// File: tb/tb_rv64g_reg_lock_tracker.sv
// Directed bench for rv64g_reg_lock_tracker with hand-computed expected values.
module tb_rv64g_reg_lock_tracker;
   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            flush_i;
   logic            launch_valid_i;
   logic            launch_ready_o;
   logic [5:0]      launch_rd_i;
   logic            launch_rd_we_i;
   logic            launch_jump_i;
   logic            exec_valid_o;
   logic            exec_ready_i;
   logic            jump_resolve_i;
   logic [1:0]      wb_valid_i;
   logic [1:0][5:0] wb_rd_i;
   logic [63:0]     locks_o;
   logic            busy_o;
   logic            wb_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   rv64g_reg_lock_tracker #(.NR(64), .NWB(2), .CW(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .launch_valid_i(launch_valid_i), .launch_ready_o(launch_ready_o),
      .launch_rd_i(launch_rd_i), .launch_rd_we_i(launch_rd_we_i),
      .launch_jump_i(launch_jump_i), .exec_valid_o(exec_valid_o),
      .exec_ready_i(exec_ready_i), .jump_resolve_i(jump_resolve_i),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
      .locks_o(locks_o), .busy_o(busy_o), .wb_err_o(wb_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic clear_in();
      flush_i        = 1'b0;
      launch_valid_i = 1'b0;
      launch_rd_i    = '0;
      launch_rd_we_i = 1'b0;
      launch_jump_i  = 1'b0;
      jump_resolve_i = 1'b0;
      wb_valid_i     = '0;
      wb_rd_i        = '0;
   endtask

   task automatic launch(input logic [5:0] rd, input logic we, input logic jmp);
      launch_valid_i = 1'b1;
      launch_rd_i    = rd;
      launch_rd_we_i = we;
      launch_jump_i  = jmp;
      #1;
   endtask

   // Clock the current inputs in, then return to idle inputs just after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
      clear_in();
      #1;
   endtask

   initial begin
      clear_in();
      exec_ready_i = 1'b1;
      rst_i        = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      chk("rst_locks", locks_o, 64'h0);
      chk("rst_busy", {63'b0, busy_o}, 64'h0);
      chk("rst_err", {63'b0, wb_err_o}, 64'h0);
      chk("rst_ready", {63'b0, launch_ready_o}, 64'h1);
      chk("rst_evalid", {63'b0, exec_valid_o}, 64'h0);
      exec_ready_i = 1'b0;
      #1;
      chk("ready_follows_exec", {63'b0, launch_ready_o}, 64'h0);
      exec_ready_i = 1'b1;

      // single lock and release
      launch(6'd5, 1'b1, 1'b0);
      chk("rd5_evalid", {63'b0, exec_valid_o}, 64'h1);
      step();
      chk("rd5_locked", locks_o, 64'h20);
      chk("rd5_busy", {63'b0, busy_o}, 64'h1);
      wb_valid_i = 2'b01; wb_rd_i[0] = 6'd5; #1;
      step();
      chk("rd5_released", locks_o, 64'h0);

      // saturation on rd7
      for (int i = 0; i < 3; i++) begin
         launch(6'd7, 1'b1, 1'b0);
         step();
      end
      chk("rd7_locked", locks_o, 64'h80);
      launch(6'd7, 1'b1, 1'b0);
      chk("rd7_sat_ready", {63'b0, launch_ready_o}, 64'h0);
      chk("rd7_sat_evalid", {63'b0, exec_valid_o}, 64'h0);
      launch_rd_we_i = 1'b0; #1;
      chk("rd7_nowe_ready", {63'b0, launch_ready_o}, 64'h1);
      launch(6'd8, 1'b1, 1'b0);
      chk("rd8_ready", {63'b0, launch_ready_o}, 64'h1);
      step();
      chk("rd8_locked", locks_o, 64'h180);
      launch(6'd7, 1'b1, 1'b0);
      wb_valid_i = 2'b10; wb_rd_i[1] = 6'd7; #1;
      chk("rd7_blocked_wb", {63'b0, launch_ready_o}, 64'h0);
      step();
      launch(6'd7, 1'b1, 1'b0);
      chk("rd7_reenabled", {63'b0, launch_ready_o}, 64'h1);
      step();
      chk("rd7_still_locked", locks_o, 64'h180);
      flush_i = 1'b1; #1;
      step();
      chk("flush_clear", locks_o, 64'h0);

      // jump interlock
      launch(6'd2, 1'b1, 1'b0);
      step();
      launch(6'd0, 1'b0, 1'b1);
      chk("jump_fire_ready", {63'b0, launch_ready_o}, 64'h1);
      step();
      chk("jump_locks_all", locks_o, {64{1'b1}});
      chk("jump_ready", {63'b0, launch_ready_o}, 64'h0);
      launch(6'd5, 1'b1, 1'b0);
      chk("jump_evalid", {63'b0, exec_valid_o}, 64'h0);
      jump_resolve_i = 1'b1; #1;
      step();
      chk("jump_resolved", locks_o, 64'h4);
      launch(6'd0, 1'b0, 1'b1);
      jump_resolve_i = 1'b1; #1;
      step();
      chk("jump_res_ignored", locks_o, {64{1'b1}});
      jump_resolve_i = 1'b1;
      wb_valid_i = 2'b01; wb_rd_i[0] = 6'd2; #1;
      step();
      chk("jump_res2", locks_o, 64'h0);

      // net delta and underflow
      launch(6'd3, 1'b1, 1'b0);
      step();
      chk("rd3_locked", locks_o, 64'h8);
      launch(6'd3, 1'b1, 1'b0);
      wb_valid_i = 2'b11; wb_rd_i[0] = 6'd3; wb_rd_i[1] = 6'd3; #1;
      chk("rd3_net_evalid", {63'b0, exec_valid_o}, 64'h1);
      step();
      chk("rd3_net_locks", locks_o, 64'h0);
      chk("rd3_net_err", {63'b0, wb_err_o}, 64'h0);
      wb_valid_i = 2'b01; wb_rd_i[0] = 6'd3; #1;
      step();
      chk("uflow_err", {63'b0, wb_err_o}, 64'h1);
      chk("uflow_locks", locks_o, 64'h0);
      flush_i = 1'b1; #1;
      step();
      chk("err_after_flush", {63'b0, wb_err_o}, 64'h1);

      // flush priority and x0
      launch(6'd9, 1'b1, 1'b1);
      flush_i = 1'b1; #1;
      chk("flush_cyc_ready", {63'b0, launch_ready_o}, 64'h1);
      step();
      chk("flush_locks", locks_o, 64'h0);
      chk("flush_busy", {63'b0, busy_o}, 64'h0);
      launch(6'd0, 1'b1, 1'b0);
      step();
      chk("x0_launch", locks_o, 64'h0);
      wb_valid_i = 2'b11; #1;
      step();
      chk("x0_wb_locks", locks_o, 64'h0);
      chk("x0_wb_busy", {63'b0, busy_o}, 64'h0);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0; #1;
      chk("rst_clears_err", {63'b0, wb_err_o}, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/rv64g_reg_lock_tracker.md
Name: rv64g_reg_lock_tracker

Overview:
Scoreboard between the instruction launcher and the execution units. It observes every launched instruction, counts outstanding writes per destination register, and drives the per-register lock vector the launcher consumes on its locks input. It forwards the launch handshake to execution and blocks launches when a destination counter would saturate or a jump is unresolved. Writeback ports release the locks.

Parameters:
NR, rv64g_pkg::NUM_REGS (64), number of tracked registers (integer plus FP); index 0 is hard-wired x0.
NWB, 2, number of writeback release ports.
CW, 2, width of each per-register outstanding-write counter; maximum count is 2^CW-1.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
flush_i  in  1  synchronous pipeline flush; drops all tracking state
launch_valid_i  in  1  launcher output valid (instr_out_valid)
launch_ready_o  out  1  ready back to launcher
launch_rd_i  in  $clog2(NR)  destination register of launched instruction
launch_rd_we_i  in  1  launched instruction writes rd
launch_jump_i  in  1  launched instruction is a jump/branch
exec_valid_o  out  1  valid towards execution units
exec_ready_i  in  1  execution units ready
jump_resolve_i  in  1  outstanding jump resolved (one-cycle pulse)
wb_valid_i  in  NWB  per-port writeback valid
wb_rd_i  in  NWB x $clog2(NR)  per-port writeback register
locks_o  out  NR  per-register lock vector to launcher
busy_o  out  1  any register locked or jump pending
wb_err_o  out  1  sticky underflow error

Behaviour:
- State: cnt[NR] (CW bits each), jump_pending (1 bit), wb_err (1 bit). All outputs derive from state plus current inputs; no internal pipeline.
- Reset (rst_i=1 at a clock edge): all cnt=0, jump_pending=0, wb_err=0. Resulting outputs: locks_o=0, busy_o=0, wb_err_o=0. launch_ready_o and exec_valid_o follow their equations.
- sat = launch_rd_we_i & (launch_rd_i!=0) & (cnt[launch_rd_i]==2^CW-1).
- block = sat | jump_pending.
- exec_valid_o = launch_valid_i & ~block.
- launch_ready_o = exec_ready_i & ~block.
- fire = launch_valid_i & launch_ready_o. exec_valid_o and launch_ready_o are combinational, zero latency.
- On fire with launch_rd_we_i=1 and rd!=0: cnt[rd] increments next cycle.
- Writes to rd=0 are never counted. Writebacks to rd=0 are ignored.
- On fire with launch_jump_i=1: jump_pending=1 next cycle. It clears on jump_resolve_i.
- jump_resolve_i while jump_pending=0 is ignored, including in the same cycle as a jump fire; in that case the new jump stays pending.
- Each port p with wb_valid_i[p]=1 and wb_rd_i[p]!=0 decrements cnt[wb_rd_i[p]] by 1. Multiple ports on the same register decrement by the number of hits.
- Same-cycle fire increment and writeback decrement on one register: the net delta is applied, e.g. cnt 1 with +1 and -1 stays 1.
- Underflow, where the net result is below 0: cnt saturates at 0 and wb_err is set sticky until rst_i. Flush does not clear wb_err.
- locks_o[r] = (cnt[r]!=0) | jump_pending. locks_o[0] = jump_pending.
- Locks update the cycle after the causing event. The launcher must not rely on same-cycle bypass.
- busy_o = |locks_o.
- flush_i=1: next cycle all cnt=0 and jump_pending=0. Flush overrides same-cycle fire, writeback and resolve. Outputs that cycle are still computed from the current state.
- Priority: rst_i > flush_i > normal update.
- CW must be ≥1. NWB must be ≥1.

Test Plan:
- Reset, then idle -> locks_o=0, busy_o=0, wb_err_o=0; with exec_ready_i=1, launch_ready_o=1.
- Launch rd=5 with we=1 -> locks_o[5]=1 one cycle later. wb_valid_i[0]=1 with wb_rd_i[0]=5 -> locks_o[5]=0 the next cycle.
- Launch rd=7 three times (CW=2) -> cnt=3. A fourth launch to rd=7 sees launch_ready_o=0 and exec_valid_o=0. A launch to rd=8 still fires. One writeback to rd=7 re-enables it.
- Launch jump -> locks_o all ones, launch_ready_o=0. jump_resolve_i pulse -> locks_o returns to the count-based vector the next cycle.
- Same cycle: launch rd=3 (cnt 1) plus writeback rd=3 on both ports -> cnt=0, locks_o[3]=0, wb_err_o=0. Then a writeback to rd=3 at cnt 0 -> wb_err_o=1 and it stays high after flush_i.
- flush_i together with launch rd=9 and a jump -> next cycle locks_o=0, busy_o=0. Writebacks to rd=0 and launches to rd=0 never change locks_o.
